// File: rtl/bank_write_ctrl_pkg.sv
// Shared register-bank definitions: bank geometry and the write-controller
// state encoding, common to the register bank and its write controller.
package bank_write_ctrl_pkg;

    localparam int BIT_ADDR = 2;
    localparam int BIT_DATO = 4;
    localparam int NREG     = 1 << BIT_ADDR;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_DEB   = 3'd1,
        ST_WRITE = 3'd2,
        ST_FILL  = 3'd3,
        ST_HOLD  = 3'd4
    } wr_state_e;

endpackage

// File: rtl/btn_debounce.sv
// Two-flop synchronizer for the raw pushbutton plus a saturating counter of
// consecutive cycles in which the synchronized level equals the requested level.
module btn_debounce #(
    parameter int DEBOUNCE_CYC = 1000000,
    parameter int CNT_W        = $clog2(DEBOUNCE_CYC + 1)
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_n,
    input  logic clr,
    input  logic lvl,
    output logic btn_s,
    output logic stable
);

    logic             sync1_r;
    logic             sync2_r;
    logic [CNT_W-1:0] cnt_r;

    // Synchronizer flops idle at the released (high) level.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1_r <= 1'b1;
            sync2_r <= 1'b1;
        end else begin
            sync1_r <= btn_n;
            sync2_r <= sync1_r;
        end
    end

    // Stable-level counter: any sample off the requested level restarts it.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_r <= '0;
        end else if (clr) begin
            cnt_r <= '0;
        end else if (sync2_r != lvl) begin
            cnt_r <= '0;
        end else if (cnt_r != CNT_W'(DEBOUNCE_CYC)) begin
            cnt_r <= cnt_r + CNT_W'(1);
        end else begin
            cnt_r <= cnt_r;
        end
    end

    assign btn_s  = sync2_r;
    assign stable = (cnt_r == CNT_W'(DEBOUNCE_CYC));

endmodule

// File: rtl/bank_write_ctrl.sv
// Pushbutton-driven register-bank writer: one debounced press issues either a
// single write or an auto-fill of every register, then waits for release.
module bank_write_ctrl #(
    parameter int BIT_ADDR     = bank_write_ctrl_pkg::BIT_ADDR,
    parameter int BIT_DATO     = bank_write_ctrl_pkg::BIT_DATO,
    parameter int DEBOUNCE_CYC = 1000000
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                btn_n,
    input  logic                fill,
    input  logic [BIT_ADDR-1:0] sw_addr,
    input  logic [BIT_DATO-1:0] sw_dat,
    output logic                reg_write,
    output logic [BIT_ADDR-1:0] addr_w,
    output logic [BIT_DATO-1:0] dat_w,
    output logic                busy,
    output logic [7:0]          wr_count
);
    import bank_write_ctrl_pkg::*;

    wr_state_e           state_r, state_s;
    logic [BIT_ADDR-1:0] idx_r, idx_s;
    logic [BIT_DATO-1:0] base_r, base_s;
    logic [BIT_ADDR-1:0] addr_s;
    logic [BIT_DATO-1:0] dat_s;
    logic                wr_s;
    logic                btn_s;
    logic                stable_s;
    logic                clr_s;
    logic                lvl_s;

    btn_debounce #(
        .DEBOUNCE_CYC(DEBOUNCE_CYC)
    ) u_btn_debounce (
        .clk    (clk),
        .rst    (rst),
        .btn_n  (btn_n),
        .clr    (clr_s),
        .lvl    (lvl_s),
        .btn_s  (btn_s),
        .stable (stable_s)
    );

    // Counter watches for a held press in DEB and for a held release in HOLD.
    always_comb begin
        clr_s = (state_r != ST_DEB) && (state_r != ST_HOLD);
        lvl_s = (state_r == ST_HOLD);
    end

    // Next state and next registered outputs; the switches are captured only
    // on the DEB exit cycle so later changes cannot disturb the operation.
    always_comb begin
        state_s = state_r;
        idx_s   = idx_r;
        base_s  = base_r;
        wr_s    = 1'b0;
        addr_s  = addr_w;
        dat_s   = dat_w;
        case (state_r)
            ST_IDLE: begin
                if (!btn_s) begin
                    state_s = ST_DEB;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_DEB: begin
                if (btn_s) begin
                    state_s = ST_IDLE;
                end else if (stable_s) begin
                    base_s = sw_dat;
                    wr_s   = 1'b1;
                    dat_s  = sw_dat;
                    if (fill) begin
                        state_s = ST_FILL;
                        idx_s   = '0;
                        addr_s  = '0;
                    end else begin
                        state_s = ST_WRITE;
                        addr_s  = sw_addr;
                    end
                end else begin
                    state_s = ST_DEB;
                end
            end
            ST_WRITE: begin
                state_s = ST_HOLD;
            end
            ST_FILL: begin
                if (idx_r == {BIT_ADDR{1'b1}}) begin
                    state_s = ST_HOLD;
                end else begin
                    idx_s  = idx_r + BIT_ADDR'(1);
                    wr_s   = 1'b1;
                    addr_s = idx_s;
                    dat_s  = base_r + BIT_DATO'(idx_s);
                end
            end
            ST_HOLD: begin
                if (stable_s && btn_s) begin
                    state_s = ST_IDLE;
                end else begin
                    state_s = ST_HOLD;
                end
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // State, sequence registers and all outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r   <= ST_IDLE;
            idx_r     <= '0;
            base_r    <= '0;
            reg_write <= 1'b0;
            addr_w    <= '0;
            dat_w     <= '0;
            busy      <= 1'b0;
            wr_count  <= 8'd0;
        end else begin
            state_r   <= state_s;
            idx_r     <= idx_s;
            base_r    <= base_s;
            reg_write <= wr_s;
            addr_w    <= addr_s;
            dat_w     <= dat_s;
            busy      <= (state_s != ST_IDLE);
            wr_count  <= wr_count + {7'd0, wr_s};
        end
    end

endmodule

// File: doc/bank_write_ctrl.md
BANK_WRITE_CTRL -- requirements
Module: bank_write_ctrl

Interface
REQ-001 SHALL have parameter BIT_ADDR, default 2, register-bank address width.
REQ-002 SHALL have parameter BIT_DATO, default 4, register-bank data width.
REQ-003 SHALL have parameter DEBOUNCE_CYC, default 1000000, stable-level cycles required (20 ms at 50 MHz).
REQ-004 SHALL have port clk, input, 1, single system clock (G_CLOCK_50 at top level).
REQ-005 SHALL have port rst, input, 1, asynchronous active-low reset.
REQ-006 SHALL have port btn_n, input, 1, raw write pushbutton, asynchronous, active-low (pressed = 0).
REQ-007 SHALL have port fill, input, 1, mode select: 0 = single write, 1 = auto-fill all registers.
REQ-008 SHALL have port sw_addr, input, BIT_ADDR, target address for single write.
REQ-009 SHALL have port sw_dat, input, BIT_DATO, write data (single) or base value (fill).
REQ-010 SHALL have port reg_write, output, 1, one-cycle write strobe to the register bank.
REQ-011 SHALL have port addr_w, output, BIT_ADDR, write address, valid while reg_write = 1.
REQ-012 SHALL have port dat_w, output, BIT_DATO, write data, valid while reg_write = 1.
REQ-013 SHALL have port busy, output, 1, high in every state except IDLE.
REQ-014 SHALL have port wr_count, output, 8, total write strobes issued since reset.

Function
REQ-015 SHALL pass btn_n through a two-flop synchronizer; btn_s is the second-flop output; all control uses btn_s only.
REQ-016 SHALL implement states IDLE, DEB, WRITE, FILL, HOLD.
REQ-017 IDLE: SHALL go to DEB in the cycle after btn_s = 0 is sampled and clear the debounce counter.
REQ-018 DEB: SHALL return to IDLE if btn_s = 1 in any cycle; after DEBOUNCE_CYC consecutive cycles with btn_s = 0 it SHALL go to WRITE if fill = 0, or to FILL with idx = 0 if fill = 1.
REQ-019 The DEB exit cycle SHALL latch sw_addr, sw_dat and fill; later switch changes SHALL NOT affect the operation in progress.
REQ-020 WRITE: SHALL hold reg_write = 1 for exactly one cycle with addr_w = latched address and dat_w = latched data, then go to HOLD.
REQ-021 FILL: SHALL hold reg_write = 1 for 2^BIT_ADDR consecutive cycles with addr_w = idx and dat_w = (base + idx) mod 2^BIT_DATO, idx running 0 to 2^BIT_ADDR-1, then go to HOLD.
REQ-022 HOLD: SHALL go to IDLE only after DEBOUNCE_CYC consecutive cycles with btn_s = 1; any btn_s = 0 restarts that count.
REQ-023 A held button SHALL produce exactly one operation (one WRITE or one FILL sequence).
REQ-024 reg_write SHALL be 0 in IDLE, DEB and HOLD; addr_w and dat_w SHALL hold their last values when reg_write = 0.
REQ-025 With btn_n held low from clock edge 0, reg_write SHALL first be 1 in cycle DEBOUNCE_CYC+3.
REQ-026 wr_count SHALL increment by 1 on every cycle with reg_write = 1 and wrap from 255 to 0.
REQ-027 All outputs SHALL be registered; no combinational path SHALL run from inputs to outputs.

Reset
REQ-028 rst = 0 SHALL asynchronously force state IDLE, synchronizer flops to 1, counters and idx to 0, and reg_write, addr_w, dat_w, busy, wr_count to 0.
REQ-029 Reset asserted mid-FILL SHALL abort the sequence with no further strobes; after release, a new press SHALL be required.

Structure
REQ-030 BIT_ADDR, BIT_DATO, NREG = 2^BIT_ADDR and the state encoding SHALL live in the shared bank package used by the register bank and this block.
REQ-031 The synchronizer and stable-level counter SHALL be one sub-module, btn_debounce, instantiated once; the FSM, latches and wr_count stay in bank_write_ctrl.

Verification (DEBOUNCE_CYC = 4)
REQ-032 Single write: fill = 0, sw_addr = 2, sw_dat = 9, btn_n low at edge 0 -> exactly one reg_write in cycle 7 with addr_w = 2, dat_w = 9; wr_count = 1.
REQ-033 Bounce: btn_n low 3 cycles, high 1 cycle, repeated 5 times, then released -> no reg_write; busy returns to 0.
REQ-034 Fill with wrap: fill = 1, sw_dat = 14, press held -> 4 consecutive strobes with (addr, dat) = (0,14), (1,15), (2,0), (3,1); wr_count = 4.
REQ-035 Hold and latch: press held 100 cycles with sw_addr/sw_dat toggled after strobe -> one strobe only, carrying the pre-strobe values; IDLE reached 4+3 cycles after release.
REQ-036 Reset mid-fill: rst = 0 asynchronously after the 2nd fill strobe -> outputs 0 immediately, no further strobes, wr_count = 0.
REQ-037 Counter wrap: 256 single writes -> wr_count = 0 after the 256th strobe.
